nibble_serializer: RTL and testbench

- Transmit end of the 4-bit nibble shift path: accepts a 32-bit word (8 nibbles) through a valid/ready load handshake.
- Presents the nibbles one at a time on `so`, advancing on each `shn` strobe from the downstream nibble shifter.
- Sits upstream of the 8-stage nibble shift register and feeds its `si`/`shn` inputs.
- A 3-state FSM plus a nibble counter sequences the word and signals completion.

---
 rtl/nibser_pkg.sv | 15 +
 rtl/nibble_serializer_if.sv | 24 ++
 rtl/nibble_xor_reduce.sv | 16 +
 rtl/nibble_serializer.sv | 108 ++++++++++
 tb/tb_nibble_serializer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/nibser_pkg.sv
// Shared constants and types for the nibble serializer.
// Optional feature macro: NIBSER_PARITY_EN (appends an XOR parity nibble).
package nibser_pkg;

  localparam int W     = 4;                  // nibble width in bits
  localparam int DEPTH = 8;                  // nibbles per word
  localparam int CNT_W = $clog2(DEPTH + 1);  // nibble counter width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } nibser_state_t;

endpackage

// File: rtl/nibble_serializer_if.sv
// Load handshake and nibble output bundle of the nibble serializer.
// master = word source / downstream shifter side, slave = serializer.
interface nibble_serializer_if import nibser_pkg::*; ();

  logic                 load_valid;
  logic                 load_ready;
  logic [W*DEPTH-1:0]   load_data;
  logic                 shn;
  logic [W-1:0]         so;
  logic                 so_valid;
  logic                 busy;
  logic                 done;

  modport master (
    output load_valid, load_data, shn,
    input  load_ready, so, so_valid, busy, done
  );

  modport slave (
    input  load_valid, load_data, shn,
    output load_ready, so, so_valid, busy, done
  );

endinterface

// File: rtl/nibble_xor_reduce.sv
// Combinational XOR of all DEPTH nibbles of a word; produces the parity
// nibble sent after the data when NIBSER_PARITY_EN is defined.
module nibble_xor_reduce import nibser_pkg::*; (
  input  logic [W*DEPTH-1:0] data,
  output logic [W-1:0]       parity
);

  // fold every nibble into the running XOR
  always_comb begin
    parity = '0;
    for (int k = 0; k < DEPTH; k++) begin
      parity = parity ^ data[W*k +: W];
    end
  end

endmodule

// File: rtl/nibble_serializer.sv
// Nibble serializer: accepts a W*DEPTH-bit word over a valid/ready handshake
// and presents it nibble 0 first on so, advancing on each shn strobe.
// Build option NIBSER_PARITY_EN: one extra XOR-parity nibble follows the data.
module nibble_serializer import nibser_pkg::*; (
  input  logic                clk,
  input  logic                rst,
  nibble_serializer_if.slave  bus
);

`ifdef NIBSER_PARITY_EN
  // count value of the final symbol (the parity nibble)
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH);
`else
  // count value of the final symbol (data nibble DEPTH-1)
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);
`endif

  nibser_state_t      state, state_next;
  logic [W-1:0]       nib [DEPTH];
  logic [CNT_W-1:0]   count;
  logic [W-1:0]       head;
  logic               ready;
  logic               load_fire;
  logic               shift_fire;

  // load_ready is a pure function of state, so no path from load_valid
  assign load_fire  = bus.load_valid && ready;
  assign shift_fire = (state == SHIFT) && bus.shn;

`ifdef NIBSER_PARITY_EN
  logic [W-1:0] parity_calc;
  logic [W-1:0] parity;

  nibble_xor_reduce u_xor (
    .data   (bus.load_data),
    .parity (parity_calc)
  );

  // parity is captured with the word and held for the final symbol
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity <= '0;
    end else if (load_fire) begin
      parity <= parity_calc;
    end
  end

  // once all data nibbles are out, the parity nibble is presented
  assign head = (count == LAST) ? parity : nib[0];
`else
  assign head = nib[0];
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state and output decode
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    bus.so     = '0;
    bus.so_valid = 1'b0;
    bus.busy   = 1'b1;
    bus.done   = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        ready    = 1'b1;
        if (bus.load_valid) state_next = SHIFT;
      end
      SHIFT: begin
        bus.so       = head;
        bus.so_valid = 1'b1;
        if (bus.shn && (count == LAST)) state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        ready      = 1'b1;
        state_next = bus.load_valid ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.load_ready = ready;

  // nibble array and counter: parallel load, shift toward index 0 on shn
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) nib[k] <= '0;
      count <= '0;
    end else if (load_fire) begin
      for (int k = 0; k < DEPTH; k++) nib[k] <= bus.load_data[W*k +: W];
      count <= '0;
    end else if (shift_fire) begin
      for (int k = 0; k < DEPTH - 1; k++) nib[k] <= nib[k+1];
      nib[DEPTH-1] <= '0;
      count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_nibble_serializer.sv
// Self-checking bench for nibble_serializer: a table of directed vectors,
// hand-written multi-cycle sequences and randomized traffic compared
// against a queue-based reference model.
module tb_nibble_serializer;
  import nibser_pkg::*;

`ifdef NIBSER_PARITY_EN
  localparam int NSYM = DEPTH + 1;
`else
  localparam int NSYM = DEPTH;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  nibble_serializer_if bus ();

  nibble_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference model: queue of nibbles still to send, plus a done flag
  logic [W-1:0] mq [$];
  bit           m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_load(input logic [W*DEPTH-1:0] d);
    logic [W-1:0] p;
    p = '0;
    mq.delete();
    for (int k = 0; k < DEPTH; k++) begin
      mq.push_back(d[W*k +: W]);
      p = p ^ d[W*k +: W];
    end
`ifdef NIBSER_PARITY_EN
    mq.push_back(p);
`endif
  endtask

  task automatic model_step();
    if (mq.size() > 0) begin
      if (bus.shn) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (bus.load_valid) model_load(bus.load_data);
    end
  endtask

  task automatic model_check();
    logic [W-1:0] e_so;
    e_so = (mq.size() > 0) ? mq[0] : '0;
    chk("so",         32'(bus.so),         32'(e_so));
    chk("so_valid",   32'(bus.so_valid),   32'(mq.size() > 0));
    chk("load_ready", 32'(bus.load_ready), 32'(mq.size() == 0));
    chk("busy",       32'(bus.busy),       32'((mq.size() > 0) || m_done));
    chk("done",       32'(bus.done),       32'(m_done));
  endtask

  // one clock: model advances with the inputs sampled at the edge, outputs checked 1ns later
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  typedef struct {
    logic               lv;
    logic [W*DEPTH-1:0] data;
    logic               shn;
    logic [W-1:0]       so;
    logic               sv;
    logic               done;
    logic               ready;
  } vec_t;

  vec_t tbl [$];

  initial begin
    int done_cnt;
    int strobes;
    int sv_cycles;
    bit seen;

    // directed vector table: basic word 0x87654321 with shn every cycle
    tbl.push_back('{1'b1, 32'h87654321, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0});
    for (int k = 2; k <= 8; k++)
      tbl.push_back('{1'b0, 32'h0, 1'b1, 4'(k), 1'b1, 1'b0, 1'b0});
`ifdef NIBSER_PARITY_EN
    tbl.push_back('{1'b0, 32'h0, 1'b1, 4'h8, 1'b1, 1'b0, 1'b0});
`endif
    tbl.push_back('{1'b0, 32'h0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1});

    // reset values, applied asynchronously before any clock edge
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.shn        = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_so",       32'(bus.so),         32'h0);
    chk("rst_so_valid", 32'(bus.so_valid),   32'h0);
    chk("rst_ready",    32'(bus.load_ready), 32'h1);
    chk("rst_busy",     32'(bus.busy),       32'h0);
    chk("rst_done",     32'(bus.done),       32'h0);
    mq.delete();
    m_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // table-driven basic word
    foreach (tbl[i]) begin
      bus.load_valid = tbl[i].lv;
      bus.load_data  = tbl[i].data;
      bus.shn        = tbl[i].shn;
      tick();
      $display("[TB] vec %0d so=%0h so_valid=%0b done=%0b", i, bus.so, bus.so_valid, bus.done);
      chk("tbl_so",    32'(bus.so),         32'(tbl[i].so));
      chk("tbl_sv",    32'(bus.so_valid),   32'(tbl[i].sv));
      chk("tbl_done",  32'(bus.done),       32'(tbl[i].done));
      chk("tbl_ready", 32'(bus.load_ready), 32'(tbl[i].ready));
    end

    // gapped strobes: shn toggles, done must follow exactly NSYM strobes
    bus.shn = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data = 32'h87654321;
    tick();
    bus.load_valid = 1'b0;
    strobes = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      bus.shn = c[0] ? 1'b0 : 1'b1;
      if (bus.shn && bus.so_valid) strobes++;
      tick();
      if (bus.done) seen = 1'b1;
    end
    $display("[TB] gapped word: %0d strobes, done_seen=%0b", strobes, seen);
    chk("gap_done_seen", 32'(seen), 32'h1);
    chk("gap_strobes",   32'(strobes), 32'(NSYM));
    bus.shn = 1'b0;
    tick();

    // back-to-back: AAAAAAAA, then FFFFFFFF held during SHIFT, then 55555555
    bus.shn = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data = 32'hAAAAAAAA;
    tick();
    bus.load_data = 32'hFFFFFFFF;
    done_cnt = 0;
    sv_cycles = 1;
    for (int c = 0; c < 100 && done_cnt < 3; c++) begin
      tick();
      if (bus.so_valid) sv_cycles++;
      if (bus.done) done_cnt++;
      else if (done_cnt == 1) bus.load_data = 32'h55555555;
      else if (done_cnt == 2) bus.load_valid = 1'b0;
    end
    $display("[TB] back-to-back: %0d words done, %0d valid cycles", done_cnt, sv_cycles);
    chk("b2b_done_cnt",  32'(done_cnt),  32'h3);
    chk("b2b_sv_cycles", 32'(sv_cycles), 32'(3 * NSYM));
    bus.load_valid = 1'b0;
    bus.shn = 1'b0;
    tick();

    // reset mid-word after three strobes
    bus.load_valid = 1'b1;
    bus.load_data = 32'h87654321;
    tick();
    bus.load_valid = 1'b0;
    bus.shn = 1'b1;
    repeat (3) tick();
    bus.shn = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    $display("[TB] mid-word reset: so=%0h so_valid=%0b done=%0b", bus.so, bus.so_valid, bus.done);
    chk("mrst_so",       32'(bus.so),         32'h0);
    chk("mrst_so_valid", 32'(bus.so_valid),   32'h0);
    chk("mrst_ready",    32'(bus.load_ready), 32'h1);
    chk("mrst_done",     32'(bus.done),       32'h0);
    mq.delete();
    m_done = 1'b0;
    #2;
    rst = 1'b0;
    tick();
    bus.load_valid = 1'b1;
    bus.load_data = 32'h0000000F;
    tick();
    chk("mrst_first", 32'(bus.so), 32'hF);
    bus.load_valid = 1'b0;
    bus.shn = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    chk("mrst_done_seen", 32'(seen), 32'h1);
    bus.shn = 1'b0;
    tick();

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      bus.load_valid = ($urandom_range(0, 2) == 0);
      bus.load_data  = $urandom;
      bus.shn        = ($urandom_range(0, 3) != 0);
      tick();
    end
    $display("[TB] random phase complete");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
